// File: rtl/framebuffer_scaler_pkg.sv
// framebuffer_scaler_pkg: shared video constants and the clog2 helper used by
// the scaler, hdmi_tx and the colour converters.
package framebuffer_scaler_pkg;

    localparam int VID_SRC_WIDTH  = 180;
    localparam int VID_SRC_HEIGHT = 120;
    localparam int VID_DATA_WIDTH = 6;

    // Never returns less than 1 so the result is always usable as a vector width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/framebuffer_scaler_read_latency_pipe.sv
// read_latency_pipe: DEPTH-stage shift register with asynchronous clear,
// used to align per-pixel flags with the SRAM read latency.
module read_latency_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/framebuffer_scaler.sv
// framebuffer_scaler: integer up-scaler reading a small source framebuffer
// from SRAM and replicating pixels/lines, with border fill outside the image.
module framebuffer_scaler
    import framebuffer_scaler_pkg::*;
#(
    parameter int SRC_WIDTH    = VID_SRC_WIDTH,
    parameter int SRC_HEIGHT   = VID_SRC_HEIGHT,
    parameter int H_SCALE      = 4,
    parameter int V_SCALE      = 4,
    parameter int DATA_WIDTH   = VID_DATA_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] BORDER_COLOR = '0,
    parameter int ADDR_WIDTH   = clog2(SRC_WIDTH * SRC_HEIGHT)
) (
    input  logic                  pixelClock,
    input  logic                  reset,
    input  logic                  inActiveDisplay,
    input  logic                  vSync,
    output logic [ADDR_WIDTH-1:0] sramAddress,
    input  logic [DATA_WIDTH-1:0] sramRdData,
    output logic [DATA_WIDTH-1:0] pixelOut,
    output logic                  pixelValid,
    output logic                  frameStart
);

    localparam int XW = clog2(SRC_WIDTH);
    localparam int YW = clog2(SRC_HEIGHT + 1);
    localparam logic [3:0]            H_LAST    = 4'(H_SCALE - 1);
    localparam logic [3:0]            V_LAST    = 4'(V_SCALE - 1);
    localparam logic [XW-1:0]         X_LAST    = XW'(SRC_WIDTH - 1);
    localparam logic [YW-1:0]         Y_END     = YW'(SRC_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(SRC_WIDTH);

    logic [3:0]            h_rep;
    logic [3:0]            v_rep;
    logic [XW-1:0]         src_x;
    logic [YW-1:0]         src_y;
    logic [ADDR_WIDTH-1:0] line_base;
    logic                  col_done;
    logic                  active_q;
    logic                  vsync_q;
    logic                  in_image;
    logic                  end_of_line;
    logic                  active_d;
    logic                  image_d;

    assign in_image    = inActiveDisplay && (src_y < Y_END) && !col_done;
    assign end_of_line = active_q && !inActiveDisplay;
    // lineBase accumulates SRC_WIDTH per source line, so no multiplier is needed.
    assign sramAddress = line_base + ADDR_WIDTH'(src_x);

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            h_rep      <= '0;
            v_rep      <= '0;
            src_x      <= '0;
            src_y      <= '0;
            line_base  <= '0;
            col_done   <= 1'b0;
            active_q   <= 1'b0;
            vsync_q    <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            active_q   <= inActiveDisplay;
            vsync_q    <= vSync;
            frameStart <= vSync && !vsync_q;
            if (vSync) begin
                h_rep     <= '0;
                v_rep     <= '0;
                src_x     <= '0;
                src_y     <= '0;
                line_base <= '0;
                col_done  <= 1'b0;
            end else if (end_of_line) begin
                h_rep    <= '0;
                src_x    <= '0;
                col_done <= 1'b0;
                v_rep    <= (v_rep == V_LAST) ? '0 : v_rep + 4'd1;
                if (v_rep == V_LAST && src_y != Y_END) begin
                    line_base <= line_base + LINE_STEP;
                    src_y     <= src_y + YW'(1);
                end
            end else if (in_image) begin
                h_rep <= (h_rep == H_LAST) ? '0 : h_rep + 4'd1;
                if (h_rep == H_LAST) begin
                    if (src_x == X_LAST) col_done <= 1'b1;
                    else src_x <= src_x + XW'(1);
                end
            end
        end
    end

    read_latency_pipe #(
        .WIDTH (2),
        .DEPTH (READ_LATENCY)
    ) u_pipe (
        .clk (pixelClock),
        .rst (reset),
        .d   ({inActiveDisplay, in_image}),
        .q   ({active_d, image_d})
    );

    assign pixelValid = active_d;
    assign pixelOut   = image_d ? sramRdData : (active_d ? BORDER_COLOR : '0);

endmodule

// File: tb/tb_framebuffer_scaler.sv
// tb_framebuffer_scaler: randomized line/frame stimulus against a scoreboard
// whose expected pixels come from plain division of column and line indices.
module tb_framebuffer_scaler;

    localparam int W  = 4;
    localparam int SH = 2;
    localparam int HS = 2;
    localparam int VS = 2;
    localparam int DW = 6;
    localparam int RL = 3;
    localparam int AW = 3;
    localparam logic [DW-1:0] BORDER = 6'h2A;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          active = 1'b0;
    logic          vsync = 1'b0;
    logic [AW-1:0] addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] pix;
    logic          valid;
    logic          fstart;

    logic [DW-1:0] mem [W*SH];
    logic [DW-1:0] rd_pipe [RL];

    typedef struct { int pixel; int cycle; } exp_t;
    exp_t sb[$];
    exp_t e;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int line     = 0;

    always #5 clk = ~clk;

    framebuffer_scaler #(
        .SRC_WIDTH    (W),
        .SRC_HEIGHT   (SH),
        .H_SCALE      (HS),
        .V_SCALE      (VS),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL),
        .BORDER_COLOR (BORDER)
    ) dut (
        .pixelClock      (clk),
        .reset           (rst),
        .inActiveDisplay (active),
        .vSync           (vsync),
        .sramAddress     (addr),
        .sramRdData      (rd_data),
        .pixelOut        (pix),
        .pixelValid      (valid),
        .frameStart      (fstart)
    );

    // SRAM with RL cycles from address to data
    always @(posedge clk) begin
        cycle <= cycle + 1;
        rd_pipe[0] <= mem[addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rd_data = rd_pipe[RL-1];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cycle);
        end
    endtask

    function automatic int exp_pixel(input int ln, input int col);
        int sx;
        int sy;
        sx = col / HS;
        sy = ln / VS;
        return (sx < W && sy < SH) ? int'(mem[sy*W + sx]) : int'(BORDER);
    endfunction

    task automatic randomize_mem();
        for (int i = 0; i < W*SH; i++) mem[i] = DW'($urandom);
    endtask

    task automatic do_vsync(input int k);
        @(posedge clk); #1;
        vsync  = 1'b1;
        active = 1'b0;
        @(posedge clk); #1;
        check("frame_start_pulse", fstart, 1);
        check("addr_after_vsync", addr, 0);
        for (int i = 1; i < k; i++) begin
            @(posedge clk); #1;
            check("frame_start_single", fstart, 0);
        end
        randomize_mem();
        @(posedge clk); #1;
        vsync = 1'b0;
        line  = 0;
    endtask

    task automatic drive_line(input int n, input int gap, input int abort_at);
        for (int c = 0; c < n; c++) begin
            if (c == abort_at) begin
                do_vsync(4);
                return;
            end
            @(posedge clk); #1;
            active = 1'b1;
            if (c / HS < W && line / VS < SH)
                check("sram_addr", addr, (line / VS) * W + c / HS);
            sb.push_back('{exp_pixel(line, c), cycle});
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            active = 1'b0;
        end
        line++;
    endtask

    task automatic mid_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            active = 1'b1;
            sb.push_back('{exp_pixel(line, c), cycle});
        end
        #2 rst = 1'b1;
        #1;
        check("async_reset_addr", addr, 0);
        check("async_reset_pixel", pix, 0);
        check("async_reset_valid", valid, 0);
        check("async_reset_fstart", fstart, 0);
        sb.delete();
        active = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        do_vsync(4);
    endtask

    // Monitor: pops one expectation per presented pixel
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pixel_out", pix, e.pixel);
                check("latency", cycle - e.cycle, RL);
            end
        end
    end

    initial begin
        int nlines;
        int n;
        randomize_mem();
        repeat (3) @(posedge clk);
        #1;
        check("reset_addr", addr, 0);
        check("reset_valid", valid, 0);
        check("reset_pixel", pix, 0);
        check("reset_fstart", fstart, 0);
        rst = 1'b0;
        do_vsync(4);
        for (int f = 0; f < 6; f++) begin
            nlines = (f == 0) ? 6 : int'($urandom_range(4, 7));
            for (int l = 0; l < nlines; l++) begin
                n = (f == 0) ? 10 : int'($urandom_range(5, 12));
                drive_line(n, int'($urandom_range(2, 5)), (f == 3 && l == 1) ? 5 : -1);
            end
            do_vsync(4);
            if (f == 4) mid_reset();
        end
        repeat (8) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
